// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 stream controller: state encoding and default sizes.
// The optional WAIT timeout is enabled with RC4_CTRL_TIMEOUT_EN.
package rc4_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LAUNCH  = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_STREAM  = 3'd3;
  localparam logic [2:0] ST_EXHAUST = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LAUNCH  = ST_LAUNCH,
    S_WAIT    = ST_WAIT,
    S_STREAM  = ST_STREAM,
    S_EXHAUST = ST_EXHAUST
  } state_t;

  localparam int DEF_NUMS_OF_BYTES  = 16;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // A key is usable when it has at least one byte and fits the core's key bus.
  function automatic logic key_len_ok(input logic [7:0] len, input int nbytes);
    return (len != 8'd0) && (int'(len) <= nbytes);
  endfunction

endpackage

// File: rtl/rc4_stream_ctrl_ks_buffer.sv
// Keystream block buffer: loads the core's whole keystream at once and serves it
// one byte at a time by index; reads past the block return zero.
module rc4_ks_buffer
  import rc4_pkg::*;
#(
  parameter int NUMS_OF_BYTES = DEF_NUMS_OF_BYTES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       clear,
  input  logic [NUMS_OF_BYTES*8-1:0] din,
  input  logic [CNT_W-1:0]           rd_idx,
  output logic [7:0]                 rd_byte
);

  localparam int IW = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;

  logic [7:0] mem [NUMS_OF_BYTES];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUMS_OF_BYTES; i++) mem[i] <= 8'h00;
    end else if (load) begin
      for (int i = 0; i < NUMS_OF_BYTES; i++) mem[i] <= din[i*8 +: 8];
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    if (rd_idx < CNT_W'(NUMS_OF_BYTES)) rd_byte = mem[rd_idx[IW-1:0]];
  end

endmodule

// File: rtl/rc4_stream_ctrl.sv
// Sequencer around the rc4_new_design core: launches a key, captures the keystream
// block, then XORs it onto a plaintext byte stream. Optional macro: RC4_CTRL_TIMEOUT_EN.
module rc4_stream_ctrl
  import rc4_pkg::*;
#(
  parameter int NUMS_OF_BYTES = DEF_NUMS_OF_BYTES,
  parameter int CNT_W         = DEF_CNT_W
`ifdef RC4_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMS_OF_BYTES*8-1:0] key_in,
  input  logic [7:0]                 key_len_in,
  input  logic                       key_load,
  output logic                       key_err,
  input  logic                       abort,
  output logic                       core_start,
  output logic [NUMS_OF_BYTES*8-1:0] core_key,
  output logic [7:0]                 core_key_length,
  input  logic                       core_done,
  input  logic [NUMS_OF_BYTES*8-1:0] core_ckey,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       exhausted,
`ifdef RC4_CTRL_TIMEOUT_EN
  output logic                       timeout,
`endif
  output logic [CNT_W-1:0]           bytes_left
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(NUMS_OF_BYTES);

  state_t           state, state_next;
  logic [CNT_W-1:0] index;
  logic             done_q;
  logic             done_edge;
  logic             abort_go;
  logic             key_accept;
  logic             key_reject;
  logic             ks_load;
  logic             ks_clear;
  logic             xfer;
  logic [7:0]       ks_byte;
  logic             tmo_hit;

`ifdef RC4_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + TW'(1);
  end

  assign tmo_hit = (state == S_WAIT) && !done_edge && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Handshakes: a byte moves on a rising clk edge where valid && ready are both high;
  // m_valid/m_data hold until m_ready, and s_ready never depends on s_valid.
  assign s_ready    = (state == S_STREAM) && (!m_valid || m_ready) && (index < N_CNT);
  assign xfer       = s_valid && s_ready;
  assign done_edge  = (state == S_WAIT) && core_done && !done_q;
  assign abort_go   = abort && (state != S_IDLE);
  assign core_start = (state == S_LAUNCH);
  assign busy       = (state != S_IDLE);
  assign exhausted  = (state == S_EXHAUST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_accept = 1'b0;
    key_reject = 1'b0;
    ks_load    = 1'b0;
    ks_clear   = 1'b0;
    if (abort_go) begin
      state_next = S_IDLE;
      ks_clear   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_EXHAUST: begin
          if (key_load) begin
            if (key_len_ok(key_len_in, NUMS_OF_BYTES)) begin
              key_accept = 1'b1;
              state_next = S_LAUNCH;
            end else begin
              key_reject = 1'b1;
            end
          end
        end
        S_LAUNCH: state_next = S_WAIT;
        S_WAIT: begin
          if (done_edge) begin
            ks_load    = 1'b1;
            state_next = S_STREAM;
          end else if (tmo_hit) begin
            key_reject = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_STREAM: begin
          if (index == N_CNT && !m_valid) state_next = S_EXHAUST;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  rc4_ks_buffer #(
    .NUMS_OF_BYTES(NUMS_OF_BYTES),
    .CNT_W        (CNT_W)
  ) u_ks_buffer (
    .clk    (clk),
    .rst    (rst),
    .load   (ks_load),
    .clear  (ks_clear),
    .din    (core_ckey),
    .rd_idx (index),
    .rd_byte(ks_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      core_key        <= '0;
      core_key_length <= 8'h00;
      key_err         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      key_err <= key_reject;
      // Tracked in every state so a done level left high before WAIT is not an edge.
      done_q  <= core_done;
      if (key_accept) begin
        core_key        <= key_in;
        core_key_length <= key_len_in;
      end
    end
  end

`ifdef RC4_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= tmo_hit && !abort_go;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      index      <= '0;
      bytes_left <= '0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
    end else if (abort_go) begin
      index      <= '0;
      bytes_left <= '0;
      m_valid    <= 1'b0;
    end else begin
      if (ks_load) begin
        index      <= '0;
        bytes_left <= N_CNT;
      end
      if (xfer) begin
        m_data     <= s_data ^ ks_byte;
        m_valid    <= 1'b1;
        index      <= index + CNT_W'(1);
        bytes_left <= bytes_left - CNT_W'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Self-checking bench for rc4_stream_ctrl: a bench-side core responder, randomized
// plaintext/backpressure, and a queue scoreboard fed from the keystream XOR rule.
module tb_rc4_stream_ctrl;

  localparam int N  = 16;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*8-1:0] key_in;
  logic [7:0]     key_len_in;
  logic           key_load;
  logic           key_err;
  logic           abort;
  logic           core_start;
  logic [N*8-1:0] core_key;
  logic [7:0]     core_key_length;
  logic           core_done;
  logic [N*8-1:0] core_ckey;
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_ready;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready;
  logic           busy;
  logic           exhausted;
  logic [CW-1:0]  bytes_left;
`ifdef RC4_CTRL_TIMEOUT_EN
  logic           timeout;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  rc4_stream_ctrl #(
    .NUMS_OF_BYTES(N),
    .CNT_W        (CW)
`ifdef RC4_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_in         (key_in),
    .key_len_in     (key_len_in),
    .key_load       (key_load),
    .key_err        (key_err),
    .abort          (abort),
    .core_start     (core_start),
    .core_key       (core_key),
    .core_key_length(core_key_length),
    .core_done      (core_done),
    .core_ckey      (core_ckey),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .busy           (busy),
    .exhausted      (exhausted),
`ifdef RC4_CTRL_TIMEOUT_EN
    .timeout        (timeout),
`endif
    .bytes_left     (bytes_left)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [N*8-1:0] k, input logic [7:0] len);
    key_in     = k;
    key_len_in = len;
    key_load   = 1'b1;
    tick();
    key_load   = 1'b0;
  endtask

  function automatic logic [N*8-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: zero plaintext, always valid/ready; 1: 0xFF with random stalls;
  // 2: random data with random stalls. Expected byte = plaintext ^ keystream byte k.
  task automatic stream(input logic [N*8-1:0] ks, input int mode, input int nbytes);
    int acc = 0;
    int cyc = 0;
    s_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    s_data  = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while ((acc < nbytes || exp_q.size() != 0 || m_valid) && cyc < 600) begin
      @(negedge clk);
      check("bytes_left_track", bytes_left, 128'(N - acc));
      if (acc >= N) check("s_ready_at_end", s_ready, 1'b0);
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data ^ ks[acc*8 +: 8]);
        acc++;
      end
      tick();
      cyc++;
      s_valid = (acc < nbytes) ? ((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      s_data  = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    end
    if (cyc >= 600) check("stream_cycle_budget", 1'b0, 1'b1);
    check("accepted_count", 128'(acc), 128'(nbytes));
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_in_hs = 1'b0;
  logic       stall_pending = 1'b0;
  logic [7:0] held_data = 8'h00;
  int         recv = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_in_hs    = 1'b0;
      stall_pending = 1'b0;
    end else begin
      if (prev_in_hs) check("latency_1cycle", m_valid, 1'b1);
      if (stall_pending && m_valid) check("hold_while_stalled", m_data, held_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
        recv++;
      end
      stall_pending = m_valid && !m_ready;
      held_data     = m_data;
      prev_in_hs    = s_valid && s_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [N*8-1:0] k1, ks;
  int             n;

  initial begin
    rst = 1'b1; key_in = '0; key_len_in = 8'h00; key_load = 1'b0; abort = 1'b0;
    core_done = 1'b0; core_ckey = '0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_exhausted", exhausted, 1'b0);
    check("rst_bytes_left", bytes_left, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_key_err", key_err, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_key", core_key, '0);
    check("rst_core_key_length", core_key_length, 8'h00);

    // Rejected key lengths from IDLE.
    load_key(rand_block(), 8'd0);
    check("reject0_key_err", key_err, 1'b1);
    check("reject0_idle", busy, 1'b0);
    tick();
    check("reject0_pulse_width", key_err, 1'b0);
    load_key(rand_block(), 8'd17);
    check("reject17_key_err", key_err, 1'b1);
    check("reject17_idle", busy, 1'b0);
    tick();
    check("reject17_pulse_width", key_err, 1'b0);

    // Valid load with the byte-ascending key, then a known keystream at full rate.
    for (int i = 0; i < N; i++) k1[i*8 +: 8] = 8'(i + 1);
    load_key(k1, 8'd16);
    check("launch_core_start", core_start, 1'b1);
    check("launch_core_key", core_key, k1);
    check("launch_core_key_length", core_key_length, 8'd16);
    check("launch_busy", busy, 1'b1);
    tick();
    check("core_start_one_cycle", core_start, 1'b0);
    load_key(rand_block(), 8'd0);
    check("wait_ignores_key_load", key_err, 1'b0);
    check("wait_key_unchanged", core_key, k1);
    tick();
    for (int i = 0; i < N; i++) ks[i*8 +: 8] = 8'(8'hA0 + i * 7);
    core_ckey = ks;
    core_done = 1'b1;
    tick();
    stream(ks, 0, N);
    repeat (2) tick();
    check("run1_exhausted", exhausted, 1'b1);
    check("run1_bytes_left", bytes_left, '0);
    check("run1_s_ready", s_ready, 1'b0);
    check("run1_recv", 128'(recv), 128'(N));

    // Reload from EXHAUST with core_done still high: only a fresh edge may start streaming.
    k1 = rand_block();
    load_key(k1, 8'd5);
    check("reload_core_start", core_start, 1'b1);
    check("reload_key_length", core_key_length, 8'd5);
    repeat (6) tick();
    check("stale_done_still_busy", busy, 1'b1);
    check("stale_done_no_stream", s_ready, 1'b0);
    check("stale_done_bytes_left", bytes_left, '0);
    core_done = 1'b0;
    tick();
    ks = rand_block();
    core_ckey = ks;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    stream(ks, 1, N);
    repeat (2) tick();
    check("run2_exhausted", exhausted, 1'b1);

    // Abort after 5 bytes, with a simultaneous key_load that must lose.
    load_key(rand_block(), 8'($urandom_range(1, N)));
    repeat ($urandom_range(1, 5)) tick();
    ks = rand_block();
    core_ckey = ks;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    stream(ks, 2, 5);
    check("pre_abort_bytes_left", bytes_left, 128'(N - 5));
    abort = 1'b1;
    key_in = rand_block();
    key_len_in = 8'd8;
    key_load = 1'b1;
    tick();
    abort = 1'b0;
    key_load = 1'b0;
    check("abort_idle", busy, 1'b0);
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_bytes_left", bytes_left, '0);
    check("abort_wins_no_start", core_start, 1'b0);
    check("abort_no_key_err", key_err, 1'b0);

    // Normal operation resumes after abort.
    k1 = rand_block();
    load_key(k1, 8'd8);
    check("resume_core_key", core_key, k1);
    repeat ($urandom_range(1, 6)) tick();
    ks = rand_block();
    core_ckey = ks;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    stream(ks, 2, N);
    repeat (2) tick();
    check("run4_exhausted", exhausted, 1'b1);
    check("run4_bytes_left", bytes_left, '0);
    load_key(rand_block(), 8'd17);
    check("exhaust_reject_key_err", key_err, 1'b1);
    check("exhaust_reject_stays", exhausted, 1'b1);

`ifdef RC4_CTRL_TIMEOUT_EN
    load_key(rand_block(), 8'd4);
    n = 0;
    while (!key_err && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycle", 128'(n), 128'd21);
    check("timeout_pulse", timeout, 1'b1);
    check("timeout_idle", busy, 1'b0);
    tick();
    check("timeout_pulse_width", timeout, 1'b0);
    check("timeout_key_err_width", key_err, 1'b0);
`else
    load_key(rand_block(), 8'd4);
    repeat (40) tick();
    check("wait_forever_busy", busy, 1'b1);
    check("wait_forever_no_key_err", key_err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wait_abort_idle", busy, 1'b0);
`endif

    // Reset in the middle of an operation.
    load_key(rand_block(), 8'd16);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_core_key", core_key, '0);
    check("midrst_core_key_length", core_key_length, 8'h00);
    check("midrst_bytes_left", bytes_left, '0);

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_stream_ctrl.md
Name: rc4_stream_ctrl

Overview:
- Sequencer wrapped around the rc4_new_design core.
- Accepts a key-load request, drives the core's start, key and key_length inputs, and waits for the core's done.
- Latches the NUMS_OF_BYTES-byte keystream block from the core's ckey output.
- XORs that keystream byte-by-byte with a plaintext stream over valid/ready handshakes and produces a ciphertext stream.

Parameters:
- NUMS_OF_BYTES, 16, keystream bytes per key and key bus width in bytes; must match the core.
- CNT_W, 8, width of the byte index and bytes_left counter; 2^CNT_W must exceed NUMS_OF_BYTES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  NUMS_OF_BYTES*8  key; byte 0 in bits [7:0].
- key_len_in  in  8  key length in bytes.
- key_load  in  1  request to load key_in and key_len_in.
- key_err  out  1  one-cycle pulse when a key load is rejected.
- abort  in  1  drops the current keystream and returns to IDLE.
- core_start  out  1  start level to the core.
- core_key  out  NUMS_OF_BYTES*8  registered key to the core.
- core_key_length  out  8  registered key length to the core.
- core_done  in  1  done from the core.
- core_ckey  in  NUMS_OF_BYTES*8  keystream from the core.
- s_data  in  8  plaintext byte.
- s_valid  in  1  plaintext valid.
- s_ready  out  1  plaintext accepted when high together with s_valid.
- m_data  out  8  ciphertext byte.
- m_valid  out  1  ciphertext valid.
- m_ready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- exhausted  out  1  high in state EXHAUST.
- bytes_left  out  CNT_W  keystream bytes not yet consumed.

Behaviour:
- Reset values: all outputs 0, core_key 0, state IDLE, index 0. Reset applies in every state, including mid-operation.
- States: IDLE, LAUNCH, WAIT, STREAM, EXHAUST.
- IDLE
  - On key_load with 1 <= key_len_in <= NUMS_OF_BYTES: register the key into core_key and core_key_length, go to LAUNCH.
  - On key_load with key_len_in = 0 or key_len_in > NUMS_OF_BYTES: pulse key_err for 1 cycle, stay in IDLE.
- LAUNCH
  - core_start=1 for exactly 1 cycle, then go to WAIT.
- WAIT
  - core_done is sampled into a register; a 0->1 edge (rising edge only) latches core_ckey into the keystream buffer.
  - On that edge: index=0, bytes_left=NUMS_OF_BYTES, go to STREAM.
  - A core_done level that is already high on entry to WAIT is not accepted; only a fresh rising edge counts.
- STREAM
  - s_ready = (!m_valid || m_ready) && (index < NUMS_OF_BYTES).
  - Transfer condition: s_valid && s_ready.
  - On transfer, registered on the next clock: m_data = s_data ^ buffer byte[index], m_valid=1, index+1, bytes_left-1.
  - Latency: 1 cycle, with full throughput of 1 byte/cycle.
  - m_valid is cleared on m_ready when no new transfer occurs in the same cycle.
  - A simultaneous m_ready and new transfer keeps m_valid=1 and loads the new byte.
  - m_data is held stable while m_valid && !m_ready.
  - When index reaches NUMS_OF_BYTES and the output register has drained (m_valid=0), go to EXHAUST.
- EXHAUST
  - s_ready=0, exhausted=1.
  - key_load is handled exactly as in IDLE.
- key_load in LAUNCH, WAIT or STREAM is ignored, with no key_err.
- abort in any non-IDLE state, next cycle:
  - state IDLE; m_valid=0; buffer cleared; bytes_left=0.
- If abort and key_load occur in the same cycle, abort wins.
- The index never wraps; s_ready is forced to 0 at NUMS_OF_BYTES.

Optional Feature:
- Macro: RC4_CTRL_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT_CYCLES, default 4096.
  - WAIT counts cycles; on reaching TIMEOUT_CYCLES without a core_done edge, pulse key_err and go to IDLE.
  - Port timeout (out, 1) pulses high for 1 cycle at the same time as that key_err.
- When undefined: WAIT has no counter and waits forever; the timeout port is absent.

Decomposition:
- Package rc4_pkg:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, STREAM=3, EXHAUST=4, 3-bit);
  - default NUMS_OF_BYTES;
  - default TIMEOUT_CYCLES.
- One sub-module, rc4_ks_buffer:
  - holds the NUMS_OF_BYTES*8 register with a load enable;
  - provides an indexed byte read port;
  - provides a clear input.
- The FSM and the handshake logic stay in the top module.

Test Plan:
- Valid load: key 0x0102..10, key_len_in 16 → core_start high for exactly 1 cycle; core_key matches key_in; busy=1.
- Stream with continuous ready: core_done rising edge with a known core_ckey; s_valid held, m_ready=1, 16 bytes of 0x00 → m_data equals the core_ckey bytes in order; 1-cycle latency; then exhausted=1 and bytes_left=0.
- Backpressure: m_ready toggled 0/1, plaintext 0xFF → m_data = ~ks[i] with no loss or duplication; m_data stable while stalled.
- Rejected keys: key_len_in 0 and key_len_in 17 → key_err pulses once for each; state remains IDLE.
- Abort after 5 bytes → next cycle IDLE, m_valid=0, bytes_left=0; reload a key → normal operation resumes.
- With RC4_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=20: core_done held low → timeout and key_err pulse at cycle 20 of WAIT; state returns to IDLE.
